regfile: RTL and testbench

//   RISC-V style integer register file: 32 x 32-bit registers, two combinational

---
 rtl/cpu_pkg.sv | 11 +
 rtl/regfile.sv | 42 ++++
 tb/tb_regfile.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types, used by the decoder, writeback stage and register file.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage : cpu_pkg

// File: rtl/regfile.sv
// Integer register file: x1..x31 stored, x0 hardwired to zero.
// Two combinational read ports and one synchronous write port.
module regfile
    import cpu_pkg::*;
(
    input  logic      clk,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  reg_addr_t rd,
    input  xword_t    wd,
    input  logic      we,
    output xword_t    rd1,
    output xword_t    rd2,
    input  logic      rst
);

    xword_t regs [1:NREGS-1];

    // A floating rst (X/Z) makes the if-condition false, so it behaves as deasserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd != '0)) begin
            regs[rd] <= wd;
        end
    end

    // No write bypass: forwarding of in-flight results is the pipeline's job.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != '0) begin
            rd1 = regs[rs1];
        end
        if (rs2 != '0) begin
            rd2 = regs[rs2];
        end
    end

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by randomized traffic
// compared against an array-based reference model.
module tb_regfile;

    import cpu_pkg::*;

    logic      clk;
    logic      rst;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    xword_t    wd;
    logic      we;
    xword_t    rd1;
    xword_t    rd2;

    int compared;
    int mismatched;

    // Reference model: architectural register contents, x0 never written.
    logic [31:0] model [32];

    regfile dut (
        .clk (clk),
        .rs1 (rs1),
        .rs2 (rs2),
        .rd  (rd),
        .wd  (wd),
        .we  (we),
        .rd1 (rd1),
        .rd2 (rd2),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] a,
                                 input logic [31:0] d, input logic [4:0] s1, input logic [4:0] s2);
        rst = r;
        we  = w;
        rd  = a;
        wd  = d;
        rs1 = s1;
        rs2 = s2;
        #1;
    endtask

    // Advance the model with the architectural rules, then let the DUT see the same edge.
    task automatic clockEdge();
        if (rst === 1'b1) begin
            for (int i = 1; i < 32; i++) model[i] = 32'h0;
        end else if (we === 1'b1 && rd != 5'd0) begin
            model[rd] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setReads(input logic [4:0] s1, input logic [4:0] s2);
        rs1 = s1;
        rs2 = s2;
        #1;
    endtask

    task automatic checkReads(input string tag);
        checkOutput({tag, "/rd1"}, rd1, model[rs1]);
        checkOutput({tag, "/rd2"}, rd2, model[rs2]);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset for one edge, then every address reads zero on both ports.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        clockEdge();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            setReads(5'(i), 5'(31 - i));
            checkOutput("reset/rd1", rd1, 32'h0);
            checkOutput("reset/rd2", rd2, 32'h0);
        end

        // Two writes, then dual reads including both ports on the same register.
        applyStimulus(1'b0, 1'b1, 5'd1, 32'd67, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 1'b1, 5'd3, 32'd69, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd3);
        checkOutput("wr13/rd1", rd1, 32'd67);
        checkOutput("wr13/rd2", rd2, 32'd69);
        setReads(5'd3, 5'd3);
        checkOutput("same/rd1", rd1, 32'd69);
        checkOutput("same/rd2", rd2, 32'd69);

        // Writes to x0 are discarded.
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        clockEdge();
        checkOutput("x0/rd1", rd1, 32'h0);
        checkOutput("x0/rd2", rd2, 32'h0);

        // we=0 leaves the target untouched.
        applyStimulus(1'b0, 1'b0, 5'd5, 32'd123, 5'd5, 5'd0);
        clockEdge();
        checkOutput("nowe/rd1", rd1, 32'h0);

        // No bypass: old value before the edge, new value after.
        applyStimulus(1'b0, 1'b1, 5'd7, 32'd10, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 1'b1, 5'd7, 32'd20, 5'd7, 5'd7);
        checkOutput("bypass/pre", rd1, 32'd10);
        clockEdge();
        checkOutput("bypass/post", rd1, 32'd20);
        checkOutput("bypass/post2", rd2, 32'd20);

        // Reset has priority over a simultaneous write.
        applyStimulus(1'b0, 1'b1, 5'd2, 32'd55, 5'd2, 5'd0);
        clockEdge();
        checkOutput("x2/written", rd1, 32'd55);
        applyStimulus(1'b1, 1'b1, 5'd2, 32'd99, 5'd2, 5'd7);
        clockEdge();
        checkOutput("rstwins/x2", rd1, 32'h0);
        checkOutput("rstwins/x7", rd2, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd2, 32'd99, 5'd2, 5'd0);
        clockEdge();
        checkOutput("rstwins/after", rd1, 32'h0);

        // An unknown rst level counts as deasserted, so the write lands.
        applyStimulus(1'bx, 1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd0);
        clockEdge();
        checkOutput("rstx/write", rd1, 32'hCAFE0009);

        // Randomized traffic: reads checked before and after each edge.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)),
                          32'($urandom),
                          5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
            checkReads("rand/pre");
            clockEdge();
            checkReads("rand/post");
            if (n % 4 == 0) begin
                rs1 = rd;
                rs2 = 5'($urandom_range(0, 31));
                #1;
                checkReads("rand/wraddr");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_regfile
